// File: rtl/fifo_mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fifo_mem_ctrl_pkg
// Shared types, default sizes and helpers for the single-clock FIFO controller.
//   DATASIZE_DEF / ADDRSIZE_DEF : default word width and address width
//   DEPTH_DEF                   : default number of array entries
//   ptr_t / count_t             : pointer (with wrap bit) and occupancy types
//   fifo_flags_t / FLAGS_RST    : registered status flags and their reset value
//   fifo_depth()                : entries for a given address width
// -----------------------------------------------------------------------------
package fifo_mem_ctrl_pkg;

    localparam int unsigned DATASIZE_DEF = 8;
    localparam int unsigned ADDRSIZE_DEF = 4;
    localparam int unsigned DEPTH_DEF    = 1 << ADDRSIZE_DEF;

    // Pointer carries one extra wrap bit above the array address.
    typedef logic [ADDRSIZE_DEF:0] ptr_t;
    // Occupancy needs to represent 0..DEPTH inclusive.
    typedef logic [ADDRSIZE_DEF:0] count_t;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_flags_t;

    localparam fifo_flags_t FLAGS_RST = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1,
        overflow:     1'b0,
        underflow:    1'b0
    };

    function automatic int unsigned fifo_depth(input int unsigned addrsize);
        return 32'd1 << addrsize;
    endfunction

endpackage

// File: rtl/fifo_mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// fifo_mem_ctrl_if
// Producer/consumer handshake bundle for fifo_mem_ctrl.
//   wr_valid_i / wr_ready_o / wr_data_i : producer side
//   rd_req_i / rd_valid_o / rd_data_o   : consumer side
// Signal suffixes are from the controller's point of view.
//   master : producer/consumer (drives valid, data, request)
//   slave  : controller
// -----------------------------------------------------------------------------
interface fifo_mem_ctrl_if
    import fifo_mem_ctrl_pkg::*;
#(
    parameter int unsigned DATASIZE = DATASIZE_DEF
);
    logic                wr_valid_i;
    logic                wr_ready_o;
    logic [DATASIZE-1:0] wr_data_i;
    logic                rd_req_i;
    logic                rd_valid_o;
    logic [DATASIZE-1:0] rd_data_o;

    modport master (
        output wr_valid_i, wr_data_i, rd_req_i,
        input  wr_ready_o, rd_valid_o, rd_data_o
    );

    modport slave (
        input  wr_valid_i, wr_data_i, rd_req_i,
        output wr_ready_o, rd_valid_o, rd_data_o
    );

endinterface

// File: rtl/fifo_mem_ctrl_ptr_ctr.sv
// -----------------------------------------------------------------------------
// fifo_mem_ctrl_ptr_ctr
// FIFO pointer register with increment and natural wrap (2*DEPTH-1 -> 0).
//   clk_i, rst_ni : clock, async active-low reset
//   clr_i         : synchronous clear to zero (has priority over inc_i)
//   inc_i         : advance pointer by one
//   ptr_o         : current registered pointer
//   ptr_nxt_o     : value the pointer takes at the next edge
// -----------------------------------------------------------------------------
module fifo_mem_ctrl_ptr_ctr #(
    parameter int unsigned ADDRSIZE = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [ADDRSIZE:0] ptr_o,
    output logic [ADDRSIZE:0] ptr_nxt_o
);

    logic [ADDRSIZE:0] r_ptr;

    always_comb begin
        ptr_nxt_o = r_ptr;
        if (clr_i) begin
            ptr_nxt_o = '0;
        end else if (inc_i) begin
            ptr_nxt_o = r_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= ptr_nxt_o;
        end
    end

    assign ptr_o = r_ptr;

endmodule

// File: rtl/fifo_mem_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_mem_ctrl
// Single-clock sequencer for a FIFO storage array: owns the write/read
// pointers, occupancy and status flags, drives the array enables/addresses
// and returns read data with a valid strobe one cycle after the request.
//   clk_i, rst_ni, flush_i         : clock, async active-low reset, sync clear
//   bus (slave)                    : producer/consumer handshake
//   mem_wen_o, mem_ren_o           : array write / read enables
//   mem_wr_addr_o, mem_rd_addr_o   : array addresses
//   mem_din_o, mem_dout_i          : array write data / registered read data
//   mem_full_o, mem_empty_o        : array gating inputs
//   full_o, empty_o, almost_full_o, almost_empty_o, count_o : status
//   overflow_o, underflow_o        : sticky error flags
// -----------------------------------------------------------------------------
module fifo_mem_ctrl
    import fifo_mem_ctrl_pkg::*;
#(
    parameter int unsigned DATASIZE = DATASIZE_DEF,
    parameter int unsigned ADDRSIZE = ADDRSIZE_DEF,
    parameter int unsigned AF_LEVEL = fifo_depth(ADDRSIZE) - 2,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    fifo_mem_ctrl_if.slave      bus,
    output logic                mem_wen_o,
    output logic                mem_ren_o,
    output logic [ADDRSIZE-1:0] mem_wr_addr_o,
    output logic [ADDRSIZE-1:0] mem_rd_addr_o,
    output logic [DATASIZE-1:0] mem_din_o,
    output logic                mem_full_o,
    output logic                mem_empty_o,
    input  logic [DATASIZE-1:0] mem_dout_i,
    output logic                full_o,
    output logic                empty_o,
    output logic                almost_full_o,
    output logic                almost_empty_o,
    output logic [ADDRSIZE:0]   count_o,
    output logic                overflow_o,
    output logic                underflow_o
);

    localparam int unsigned     CW     = ADDRSIZE + 1;
    localparam logic [ADDRSIZE:0] AF_CNT = CW'(AF_LEVEL);
    localparam logic [ADDRSIZE:0] AE_CNT = CW'(AE_LEVEL);

    logic              w_wr_fire;
    logic              w_rd_fire;
    logic [ADDRSIZE:0] w_wptr;
    logic [ADDRSIZE:0] w_wptr_nxt;
    logic [ADDRSIZE:0] w_rptr;
    logic [ADDRSIZE:0] w_rptr_nxt;
    logic [ADDRSIZE:0] w_count_nxt;
    fifo_flags_t       w_flags_nxt;

    logic [ADDRSIZE:0]   r_count;
    fifo_flags_t         r_flags;
    logic                r_rd_pend;
    logic [DATASIZE-1:0] r_rd_hold;

    // Gating uses the registered flags of the current cycle, so a write is
    // refused when full even if a read frees a slot in the same cycle.
    assign w_wr_fire = bus.wr_valid_i & ~r_flags.full  & ~flush_i;
    assign w_rd_fire = bus.rd_req_i   & ~r_flags.empty & ~flush_i;

    fifo_mem_ctrl_ptr_ctr #(.ADDRSIZE(ADDRSIZE)) u_wr_ptr (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (flush_i),
        .inc_i     (w_wr_fire),
        .ptr_o     (w_wptr),
        .ptr_nxt_o (w_wptr_nxt)
    );

    fifo_mem_ctrl_ptr_ctr #(.ADDRSIZE(ADDRSIZE)) u_rd_ptr (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (flush_i),
        .inc_i     (w_rd_fire),
        .ptr_o     (w_rptr),
        .ptr_nxt_o (w_rptr_nxt)
    );

    always_comb begin
        w_count_nxt = r_count;
        if (flush_i) begin
            w_count_nxt = '0;
        end else begin
            case ({w_wr_fire, w_rd_fire})
                2'b10:   w_count_nxt = r_count + 1'b1;
                2'b01:   w_count_nxt = r_count - 1'b1;
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // Flags are computed from next-state pointers/count so the registered
    // versions are correct in the same cycle the pointers move.
    always_comb begin
        w_flags_nxt              = r_flags;
        w_flags_nxt.empty        = (w_wptr_nxt == w_rptr_nxt);
        w_flags_nxt.full         = (w_wptr_nxt[ADDRSIZE] != w_rptr_nxt[ADDRSIZE]) &&
                                   (w_wptr_nxt[ADDRSIZE-1:0] == w_rptr_nxt[ADDRSIZE-1:0]);
        w_flags_nxt.almost_full  = (w_count_nxt >= AF_CNT);
        w_flags_nxt.almost_empty = (w_count_nxt <= AE_CNT);
        if (flush_i) begin
            w_flags_nxt.overflow  = 1'b0;
            w_flags_nxt.underflow = 1'b0;
        end else begin
            w_flags_nxt.overflow  = r_flags.overflow  | (bus.wr_valid_i & r_flags.full);
            w_flags_nxt.underflow = r_flags.underflow | (bus.rd_req_i   & r_flags.empty);
        end
    end

    // r_rd_pend is not cleared by flush, so a read accepted in the cycle
    // before a flush still returns its data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count   <= '0;
            r_flags   <= FLAGS_RST;
            r_rd_pend <= 1'b0;
            r_rd_hold <= '0;
        end else begin
            r_count   <= w_count_nxt;
            r_flags   <= w_flags_nxt;
            r_rd_pend <= w_rd_fire;
            if (r_rd_pend) begin
                r_rd_hold <= mem_dout_i;
            end
        end
    end

    // The array output is only valid in the cycle after the read enable;
    // pass it through then and hold the captured copy afterwards.
    assign bus.rd_data_o  = r_rd_pend ? mem_dout_i : r_rd_hold;
    assign bus.rd_valid_o = r_rd_pend;
    assign bus.wr_ready_o = ~r_flags.full;

    assign mem_wen_o     = w_wr_fire;
    assign mem_ren_o     = w_rd_fire;
    assign mem_wr_addr_o = w_wptr[ADDRSIZE-1:0];
    assign mem_rd_addr_o = w_rptr[ADDRSIZE-1:0];
    assign mem_din_o     = bus.wr_data_i;
    assign mem_full_o    = r_flags.full;
    assign mem_empty_o   = r_flags.empty;

    assign full_o         = r_flags.full;
    assign empty_o        = r_flags.empty;
    assign almost_full_o  = r_flags.almost_full;
    assign almost_empty_o = r_flags.almost_empty;
    assign overflow_o     = r_flags.overflow;
    assign underflow_o    = r_flags.underflow;
    assign count_o        = r_count;

endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_mem_ctrl
// Directed bench for fifo_mem_ctrl with a behavioural storage array and a
// queue-based reference model of FIFO contents, flags and pointers.
// -----------------------------------------------------------------------------
module tb_fifo_mem_ctrl;
    import fifo_mem_ctrl_pkg::*;

    localparam int unsigned DEPTH = DEPTH_DEF;

    logic       clk;
    logic       rst_ni;
    logic       flush;
    logic       mem_wen, mem_ren, mem_full, mem_empty;
    logic [3:0] mem_wr_addr, mem_rd_addr;
    logic [7:0] mem_din, mem_dout;
    logic       full, empty, afull, aempty, ovf, unf;
    logic [4:0] count;

    fifo_mem_ctrl_if #(.DATASIZE(8)) bus ();

    fifo_mem_ctrl #(
        .DATASIZE (8),
        .ADDRSIZE (4)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .flush_i        (flush),
        .bus            (bus),
        .mem_wen_o      (mem_wen),
        .mem_ren_o      (mem_ren),
        .mem_wr_addr_o  (mem_wr_addr),
        .mem_rd_addr_o  (mem_rd_addr),
        .mem_din_o      (mem_din),
        .mem_full_o     (mem_full),
        .mem_empty_o    (mem_empty),
        .mem_dout_i     (mem_dout),
        .full_o         (full),
        .empty_o        (empty),
        .almost_full_o  (afull),
        .almost_empty_o (aempty),
        .count_o        (count),
        .overflow_o     (ovf),
        .underflow_o    (unf)
    );

    // Storage array with one-cycle registered read.
    logic [7:0] mem [DEPTH];
    always @(posedge clk) begin
        if (mem_wen) mem[mem_wr_addr] <= mem_din;
        if (mem_ren) mem_dout <= mem[mem_rd_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned tests = 0;
    int unsigned fails = 0;

    // Reference model
    logic [7:0] sb [$];
    logic       m_pend;
    logic [7:0] m_exp;
    logic       m_ovf, m_unf;
    ptr_t       m_wp, m_rp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_pend = 1'b0;
        m_exp  = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_wp   = '0;
        m_rp   = '0;
    endtask

    task automatic chk_state();
        count_t exp_cnt;
        exp_cnt = count_t'(sb.size());
        chk("rd_valid", bus.rd_valid_o, m_pend);
        if (m_pend) chk("rd_data", bus.rd_data_o, m_exp);
        chk("count", count, exp_cnt);
        chk("empty", empty, exp_cnt == 0);
        chk("full", full, exp_cnt == count_t'(DEPTH));
        chk("wr_ready", bus.wr_ready_o, exp_cnt != count_t'(DEPTH));
        chk("mem_empty", mem_empty, exp_cnt == 0);
        chk("mem_full", mem_full, exp_cnt == count_t'(DEPTH));
        chk("almost_full", afull, exp_cnt >= count_t'(DEPTH - 2));
        chk("almost_empty", aempty, exp_cnt <= 2);
        chk("overflow", ovf, m_ovf);
        chk("underflow", unf, m_unf);
        chk("wr_addr", mem_wr_addr, m_wp[3:0]);
        chk("rd_addr", mem_rd_addr, m_rp[3:0]);
    endtask

    // One clock of stimulus: drive, check enables, clock, advance model, check state.
    task automatic cycle(input logic wv, input logic [7:0] wd, input logic rr, input logic fl);
        logic wf, rf;
        int   n;
        n  = sb.size();
        bus.wr_valid_i = wv;
        bus.wr_data_i  = wd;
        bus.rd_req_i   = rr;
        flush          = fl;
        wf = wv && (n != DEPTH) && !fl;
        rf = rr && (n != 0) && !fl;
        #1;
        chk("mem_wen", mem_wen, wf);
        chk("mem_ren", mem_ren, rf);
        chk("rd_valid_pre", bus.rd_valid_o, m_pend);
        if (wf) chk("mem_din", mem_din, wd);
        @(posedge clk);
        #1;
        m_pend = rf;
        if (rf) m_exp = sb.pop_front();
        if (wf) sb.push_back(wd);
        if (fl) begin
            sb.delete();
            m_wp  = '0;
            m_rp  = '0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (wf) m_wp++;
            if (rf) m_rp++;
            if (wv && n == DEPTH) m_ovf = 1'b1;
            if (rr && n == 0)     m_unf = 1'b1;
        end
        chk_state();
    endtask

    initial begin
        rst_ni         = 1'b0;
        flush          = 1'b0;
        bus.wr_valid_i = 1'b0;
        bus.wr_data_i  = '0;
        bus.rd_req_i   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_state();
        chk("rst_rd_data", bus.rd_data_o, 8'h00);
        rst_ni = 1'b1;

        // Fill to full, then one extra write
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);

        // Drain in order, then one extra request
        for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Refill; simultaneous write/read while full
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        // Read then flush: the earlier read still returns
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Simultaneous write/read while empty
        cycle(1'b1, 8'h77, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Set underflow, prime, stream across wrap with a mid-stream flush
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b1, (i == 20));
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // Reset with a read in flight
        cycle(1'b1, 8'hC1, 1'b0, 1'b0);
        cycle(1'b1, 8'hC2, 1'b0, 1'b0);
        bus.wr_valid_i = 1'b0;
        bus.rd_req_i   = 1'b1;
        @(posedge clk);
        #1;
        rst_ni = 1'b0;
        #1;
        model_reset();
        chk_state();
        chk("rst_rd_data", bus.rd_data_o, 8'h00);
        bus.rd_req_i = 1'b0;
        @(posedge clk);
        #1;
        chk_state();
        rst_ni = 1'b1;
        cycle(1'b1, 8'hD5, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
